// File: rtl/huff_pkg.sv
// ---------------------------------------------------------------------------
// huff_pkg
// Shared definitions for the Huffman encoder arbiter slice:
//   - FSM state encoding (legacy-compatible localparam constants)
//   - default symbol data width, width-field width and packet length limit
//   - byte width used for tail padding
//   - clog2 helper used to size requester IDs and counters
// No ports (package).
// ---------------------------------------------------------------------------
package huff_pkg;

  localparam int BYTE_W      = 8;
  localparam int DEF_W       = 8;
  localparam int DEF_C       = 4;
  localparam int DEF_MAX_SYM = 255;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_HDR    = 2'd1;
  localparam arb_state_t ST_STREAM = 2'd2;
  localparam arb_state_t ST_PAD    = 2'd3;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/huff_enc_arbiter_if.sv
// ---------------------------------------------------------------------------
// huff_enc_arbiter_if
// Bundles the requester-side handshake and the packer-side symbol bus of the
// Huffman encoder arbiter.
//   req_valid [N]    per-requester symbol valid
//   req_last  [N]    symbol closes its packet
//   req_data  [N*W]  packed MSB-aligned codes, requester i at [i*W +: W]
//   req_width [N*C]  packed code lengths, requester i at [i*C +: C]
//   req_ready [N]    symbol accepted when valid & ready
//   enc_d     [W]    symbol to packer
//   enc_w     [C]    symbol length to packer
//   enc_en           symbol strobe to packer
//   grant_id  [ID_W] currently / last granted requester
//   pkt_done         packet fully issued (padding included)
//   err              sticky error flag
// Modports: master = requesters + packer side (drives requests),
//           slave  = arbiter.
// ---------------------------------------------------------------------------
interface huff_enc_arbiter_if
  import huff_pkg::*;
#(
  parameter int N = 4,
  parameter int W = DEF_W,
  parameter int C = DEF_C
);

  localparam int ID_W = clog2(N);

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*W-1:0]  req_data;
  logic [N*C-1:0]  req_width;
  logic [N-1:0]    req_ready;

  logic [W-1:0]    enc_d;
  logic [C-1:0]    enc_w;
  logic            enc_en;
  logic [ID_W-1:0] grant_id;
  logic            pkt_done;
  logic            err;

  modport master (
    output req_valid, req_last, req_data, req_width,
    input  req_ready, enc_d, enc_w, enc_en, grant_id, pkt_done, err
  );

  modport slave (
    input  req_valid, req_last, req_data, req_width,
    output req_ready, enc_d, enc_w, enc_en, grant_id, pkt_done, err
  );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: returns the first set request bit
// strictly after ptr, searching cyclically. The pointer register is owned by
// the parent so it only moves when a grant is actually taken.
//   req     [N]    request vector
//   ptr     [ID_W] last granted index
//   gnt     [N]    one-hot grant (all zero when no request)
//   gnt_idx [ID_W] index of the granted bit (0 when no request)
// ---------------------------------------------------------------------------
module rr_arbiter
  import huff_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx
);

  int              cand;
  logic [ID_W-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the nearest requester after
  // ptr overwrites any earlier hit; offset N wraps back to ptr itself.
  always_comb begin
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = N; off >= 1; off--) begin
      cand     = (int'(ptr) + off) % N;
      cand_idx = ID_W'(cand);
      if (req[cand_idx]) begin
        gnt_idx = cand_idx;
      end
    end
    gnt = '0;
    if (req != '0) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/huff_enc_arbiter.sv
// ---------------------------------------------------------------------------
// huff_enc_arbiter
// Round-robin scheduler sharing one Huffman bit-packer among N symbol
// streams. A requester keeps the grant for a whole packet; its symbols are
// forwarded one per clock and the packet tail is zero-padded to a byte
// boundary so packed bytes never mix two packets.
//
// Optional feature: define HUFF_ARB_HDR_EN to prefix every packet with a
// clog2(N)-bit channel-ID symbol (HDR state). Undefined: payload only.
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   huff_enc_arbiter_if.slave (requests in, packer symbols out)
// ---------------------------------------------------------------------------
module huff_enc_arbiter
  import huff_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = DEF_W,
  parameter int C       = DEF_C,
  parameter int MAX_SYM = DEF_MAX_SYM
) (
  input  logic              clk,
  input  logic              rst,
  huff_enc_arbiter_if.slave bus
);

  localparam int ID_W = clog2(N);
  localparam int BC_W = clog2(BYTE_W);
  localparam int SC_W = clog2(MAX_SYM + 1);

  localparam logic [C-1:0]    W_AS_C = C'(W);
  localparam logic [SC_W-1:0] MAX_SC = SC_W'(MAX_SYM);

  arb_state_t      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic [BC_W-1:0] bit_cnt;
  logic [SC_W-1:0] sym_cnt;

  logic [W-1:0]    enc_d;
  logic [C-1:0]    enc_w;
  logic            enc_en;
  logic            pkt_done;
  logic            err;

  logic [N-1:0]    arb_gnt;
  logic [ID_W-1:0] arb_idx;

  logic            sel_valid;
  logic            sel_last;
  logic [W-1:0]    sel_data;
  logic [C-1:0]    sel_width;

  logic            handshake;
  logic            sym_fwd;
  logic            sym_wide;
  logic            cnt_hit;
  logic            pkt_end;
  logic [C-1:0]    eff_w;
  logic [BC_W-1:0] bit_next;
  logic [SC_W-1:0] sym_next;

  rr_arbiter #(
    .N    (N),
    .ID_W (ID_W)
  ) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Pick out the granted requester's symbol fields.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_width = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*W +: W];
        sel_width = bus.req_width[i*C +: C];
      end
    end
  end

  // Ready depends on registered state only, never on req_valid.
  always_comb begin
    bus.req_ready = '0;
    if (state == ST_STREAM) begin
      bus.req_ready[grant_id] = 1'b1;
    end
  end

  // Per-symbol bookkeeping. Oversized widths are clamped to W; the bit
  // counter only needs the position within the current byte, so the add
  // simply wraps. Zero-width symbols are dropped and leave both counters.
  always_comb begin
    handshake = (state == ST_STREAM) && sel_valid;
    sym_fwd   = (sel_width != '0);
    sym_wide  = (sel_width > W_AS_C);
    eff_w     = sym_wide ? W_AS_C : sel_width;
    bit_next  = sym_fwd ? (bit_cnt + BC_W'(eff_w)) : bit_cnt;
    sym_next  = sym_fwd ? (sym_cnt + SC_W'(1)) : sym_cnt;
    cnt_hit   = sym_fwd && (sym_next == MAX_SC);
    pkt_end   = sel_last || cnt_hit;
  end

  // Main FSM and registered packer outputs. Strobes default low every cycle;
  // a packet ends either into PAD (byte not yet full) or straight back to
  // IDLE with pkt_done riding on the final symbol. A packet cut short by the
  // symbol limit flags err but leaves the requester's remaining symbols for
  // a later grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= ID_W'(N - 1);
      grant_id <= '0;
      bit_cnt  <= '0;
      sym_cnt  <= '0;
      enc_d    <= '0;
      enc_w    <= '0;
      enc_en   <= 1'b0;
      pkt_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      enc_en   <= 1'b0;
      pkt_done <= 1'b0;
      enc_d    <= '0;
      enc_w    <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_gnt != '0) begin
            grant_id <= arb_idx;
            rr_ptr   <= arb_idx;
            bit_cnt  <= '0;
            sym_cnt  <= '0;
`ifdef HUFF_ARB_HDR_EN
            state    <= ST_HDR;
`else
            state    <= ST_STREAM;
`endif
          end
        end
`ifdef HUFF_ARB_HDR_EN
        ST_HDR: begin
          enc_en  <= 1'b1;
          enc_d   <= W'(grant_id) << (W - ID_W);
          enc_w   <= C'(ID_W);
          bit_cnt <= BC_W'(ID_W);
          state   <= ST_STREAM;
        end
`endif
        ST_STREAM: begin
          if (handshake) begin
            if (sym_fwd) begin
              enc_en <= 1'b1;
              enc_d  <= sel_data;
              enc_w  <= eff_w;
            end
            bit_cnt <= bit_next;
            sym_cnt <= sym_next;
            if (sym_wide || (cnt_hit && !sel_last)) begin
              err <= 1'b1;
            end
            if (pkt_end) begin
              if (bit_next != '0) begin
                state <= ST_PAD;
              end else begin
                state    <= ST_IDLE;
                pkt_done <= 1'b1;
              end
            end
          end
        end
        ST_PAD: begin
          enc_en   <= 1'b1;
          enc_w    <= C'(BYTE_W) - C'(bit_cnt);
          pkt_done <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.enc_d    = enc_d;
  assign bus.enc_w    = enc_w;
  assign bus.enc_en   = enc_en;
  assign bus.grant_id = grant_id;
  assign bus.pkt_done = pkt_done;
  assign bus.err      = err;

endmodule

// File: tb/tb_huff_enc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_huff_enc_arbiter
// Self-checking bench for huff_enc_arbiter (N=4, W=8, C=4, MAX_SYM=3).
// Expected packer strobes come from a small packet model and are queued when
// stimulus is scheduled; a monitor records every enc_en / pkt_done cycle and
// each test task pops and compares them. Works with or without
// HUFF_ARB_HDR_EN defined.
// ---------------------------------------------------------------------------
module tb_huff_enc_arbiter;
  import huff_pkg::*;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int C       = 4;
  localparam int MAX_SYM = 3;
  localparam int ID_W    = clog2(N);

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] w;
    logic       done;
    logic [1:0] g;
  } strobe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  huff_enc_arbiter_if #(.N(N), .W(W), .C(C)) bus ();

  huff_enc_arbiter #(
    .N       (N),
    .W       (W),
    .C       (C),
    .MAX_SYM (MAX_SYM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  strobe_t exp_q[$];
  strobe_t obs_buf[0:1023];
  int      obs_wr = 0;
  int      obs_rd = 0;
  int      checks = 0;
  int      fails  = 0;
  int      m_bits = 0;
  int      m_syms = 0;
  logic    m_err  = 1'b0;

  // Record every cycle the packer sees a strobe or a done pulse.
  always @(negedge clk) begin
    if (!rst && (bus.enc_en || bus.pkt_done) && obs_wr < 1024) begin
      obs_buf[obs_wr] = {bus.enc_d, bus.enc_w, bus.pkt_done, bus.grant_id};
      obs_wr = obs_wr + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang, want completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void exp_push(logic [7:0] d, int w, logic done, int g);
    strobe_t s;
    s.d    = d;
    s.w    = 4'(w);
    s.done = done;
    s.g    = 2'(g);
    exp_q.push_back(s);
  endfunction

  function automatic void exp_begin(int g);
    m_bits = 0;
    m_syms = 0;
`ifdef HUFF_ARB_HDR_EN
    exp_push(8'(g) << (8 - ID_W), ID_W, 1'b0, g);
    m_bits = ID_W % 8;
`endif
  endfunction

  // Returns 1 when the packet closes after this symbol.
  function automatic bit exp_sym(int g, logic [7:0] d, int w, bit last);
    int eff;
    bit ended;
    if (w == 0) begin
      ended = last;
      if (last && m_bits == 0) exp_push(8'h00, 0, 1'b1, g);
    end else begin
      eff    = (w > 8) ? 8 : w;
      m_bits = (m_bits + eff) % 8;
      m_syms = m_syms + 1;
      if (w > 8) m_err = 1'b1;
      if (m_syms == MAX_SYM && !last) m_err = 1'b1;
      ended  = last || (m_syms == MAX_SYM);
      exp_push(d, eff, ended && (m_bits == 0), g);
    end
    if (ended && m_bits != 0) exp_push(8'h00, 8 - m_bits, 1'b1, g);
    return ended;
  endfunction

  task automatic send_sym(int r, logic [7:0] d, logic [3:0] w, bit last, int gap);
    repeat (gap) @(negedge clk);
    bus.req_valid[r]         = 1'b1;
    bus.req_last[r]          = last;
    bus.req_data[r*W +: W]   = d;
    bus.req_width[r*C +: C]  = w;
    for (int t = 0; t < 100; t++) begin
      if (bus.req_ready[r]) break;
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid[r] = 1'b0;
    bus.req_last[r]  = 1'b0;
  endtask

  task automatic send_pair(int ra, logic [7:0] da, int rb, logic [7:0] db);
    logic [N-1:0] acc;
    bus.req_data[ra*W +: W]  = da;
    bus.req_data[rb*W +: W]  = db;
    bus.req_width[ra*C +: C] = 4'd8;
    bus.req_width[rb*C +: C] = 4'd8;
    bus.req_last[ra]         = 1'b1;
    bus.req_last[rb]         = 1'b1;
    bus.req_valid[ra]        = 1'b1;
    bus.req_valid[rb]        = 1'b1;
    for (int t = 0; t < 100 && bus.req_valid != '0; t++) begin
      acc = bus.req_ready & bus.req_valid;
      @(negedge clk);
      bus.req_valid = bus.req_valid & ~acc;
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
  endtask

  task automatic settle();
    for (int t = 0; t < 300 && (obs_wr - obs_rd) < exp_q.size(); t++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL reset req_ready: got %b want 0000", bus.req_ready); end
    checks++; if ({bus.enc_en, bus.enc_d, bus.enc_w} !== 13'd0) begin fails++; $display("[TB] FAIL reset enc: got en=%b d=%h w=%0d want all zero", bus.enc_en, bus.enc_d, bus.enc_w); end
    checks++; if (bus.grant_id !== 2'd0) begin fails++; $display("[TB] FAIL reset grant_id: got %0d want 0", bus.grant_id); end
    checks++; if ({bus.pkt_done, bus.err} !== 2'b00) begin fails++; $display("[TB] FAIL reset flags: got done=%b err=%b want 0 0", bus.pkt_done, bus.err); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL idle req_ready: got %b want 0000", bus.req_ready); end
  endtask

  task automatic test_round_robin();
    strobe_t e, o;
    exp_begin(0); void'(exp_sym(0, 8'h11, 8, 1'b1));
    exp_begin(2); void'(exp_sym(2, 8'h22, 8, 1'b1));
    send_pair(0, 8'h11, 2, 8'h22);
    settle();
    checks++; if (bus.grant_id !== 2'd2) begin fails++; $display("[TB] FAIL rr grant_id: got %0d want 2", bus.grant_id); end
    exp_begin(3); void'(exp_sym(3, 8'h33, 8, 1'b1));
    exp_begin(0); void'(exp_sym(0, 8'h44, 8, 1'b1));
    send_pair(0, 8'h44, 3, 8'h33);
    settle();
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front(); o = obs_buf[obs_rd]; obs_rd++;
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL rr strobe: got d=%h w=%0d done=%b g=%0d want d=%h w=%0d done=%b g=%0d", o.d, o.w, o.done, o.g, e.d, e.w, e.done, e.g); end
    end
    checks++;
    if (exp_q.size() != 0 || obs_rd != obs_wr) begin fails++; $display("[TB] FAIL rr count: got %0d extra strobes want 0, %0d missing", obs_wr - obs_rd, exp_q.size()); exp_q.delete(); obs_rd = obs_wr; end
  endtask

  task automatic test_single_pad();
    strobe_t e, o;
    exp_begin(0);
    void'(exp_sym(0, 8'hA0, 3, 1'b0));
    void'(exp_sym(0, 8'hC0, 2, 1'b1));
    send_sym(0, 8'hA0, 4'd3, 1'b0, 0);
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL stall req_ready: got %b want 0001", bus.req_ready); end
    send_sym(0, 8'hC0, 4'd2, 1'b1, 1);
    settle();
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front(); o = obs_buf[obs_rd]; obs_rd++;
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL pad strobe: got d=%h w=%0d done=%b g=%0d want d=%h w=%0d done=%b g=%0d", o.d, o.w, o.done, o.g, e.d, e.w, e.done, e.g); end
    end
    checks++;
    if (exp_q.size() != 0 || obs_rd != obs_wr) begin fails++; $display("[TB] FAIL pad count: got %0d extra strobes want 0, %0d missing", obs_wr - obs_rd, exp_q.size()); exp_q.delete(); obs_rd = obs_wr; end
  endtask

  task automatic test_requester3();
    strobe_t e, o;
    exp_begin(3);
    void'(exp_sym(3, 8'h80, 1, 1'b1));
    send_sym(3, 8'h80, 4'd1, 1'b1, 0);
    settle();
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front(); o = obs_buf[obs_rd]; obs_rd++;
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL r3 strobe: got d=%h w=%0d done=%b g=%0d want d=%h w=%0d done=%b g=%0d", o.d, o.w, o.done, o.g, e.d, e.w, e.done, e.g); end
    end
    checks++;
    if (exp_q.size() != 0 || obs_rd != obs_wr) begin fails++; $display("[TB] FAIL r3 count: got %0d extra strobes want 0, %0d missing", obs_wr - obs_rd, exp_q.size()); exp_q.delete(); obs_rd = obs_wr; end
  endtask

  task automatic test_width_err();
    strobe_t e, o;
    checks++; if (bus.err !== m_err) begin fails++; $display("[TB] FAIL err before widths: got %b want %b", bus.err, m_err); end
    exp_begin(1);
    void'(exp_sym(1, 8'h55, 0, 1'b0));
    void'(exp_sym(1, 8'hAB, 12, 1'b0));
    void'(exp_sym(1, 8'h80, 1, 1'b1));
    send_sym(1, 8'h55, 4'd0, 1'b0, 0);
    send_sym(1, 8'hAB, 4'd12, 1'b0, 0);
    send_sym(1, 8'h80, 4'd1, 1'b1, 0);
    settle();
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front(); o = obs_buf[obs_rd]; obs_rd++;
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL width strobe: got d=%h w=%0d done=%b g=%0d want d=%h w=%0d done=%b g=%0d", o.d, o.w, o.done, o.g, e.d, e.w, e.done, e.g); end
    end
    checks++;
    if (exp_q.size() != 0 || obs_rd != obs_wr) begin fails++; $display("[TB] FAIL width count: got %0d extra strobes want 0, %0d missing", obs_wr - obs_rd, exp_q.size()); exp_q.delete(); obs_rd = obs_wr; end
    checks++; if (bus.err !== m_err) begin fails++; $display("[TB] FAIL err after wide: got %b want %b", bus.err, m_err); end
    repeat (5) @(negedge clk);
    checks++; if (bus.err !== m_err) begin fails++; $display("[TB] FAIL err sticky: got %b want %b", bus.err, m_err); end
  endtask

  task automatic test_max_sym();
    strobe_t e, o;
    exp_begin(2);
    for (int i = 0; i < 5; i++) begin
      if (exp_sym(2, 8'h80, 1, i == 4) && i < 4) exp_begin(2);
    end
    for (int i = 0; i < 5; i++) begin
      send_sym(2, 8'h80, 4'd1, i == 4, 0);
    end
    settle();
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front(); o = obs_buf[obs_rd]; obs_rd++;
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL maxsym strobe: got d=%h w=%0d done=%b g=%0d want d=%h w=%0d done=%b g=%0d", o.d, o.w, o.done, o.g, e.d, e.w, e.done, e.g); end
    end
    checks++;
    if (exp_q.size() != 0 || obs_rd != obs_wr) begin fails++; $display("[TB] FAIL maxsym count: got %0d extra strobes want 0, %0d missing", obs_wr - obs_rd, exp_q.size()); exp_q.delete(); obs_rd = obs_wr; end
    checks++; if (bus.err !== m_err) begin fails++; $display("[TB] FAIL maxsym err: got %b want %b", bus.err, m_err); end
  endtask

  task automatic test_reset_mid_packet();
    strobe_t e, o;
    exp_begin(1);
    void'(exp_sym(1, 8'hE0, 3, 1'b0));
    send_sym(1, 8'hE0, 4'd3, 1'b0, 0);
    settle();
    checks++; if (bus.req_ready !== 4'b0010) begin fails++; $display("[TB] FAIL midpkt req_ready: got %b want 0010", bus.req_ready); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL rstmid req_ready: got %b want 0000", bus.req_ready); end
    checks++; if ({bus.enc_en, bus.enc_d, bus.enc_w, bus.pkt_done} !== 14'd0) begin fails++; $display("[TB] FAIL rstmid enc: got en=%b d=%h w=%0d done=%b want all zero", bus.enc_en, bus.enc_d, bus.enc_w, bus.pkt_done); end
    checks++; if ({bus.grant_id, bus.err} !== 3'd0) begin fails++; $display("[TB] FAIL rstmid state: got grant=%0d err=%b want 0 0", bus.grant_id, bus.err); end
    rst   = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
    exp_begin(0); void'(exp_sym(0, 8'h5A, 8, 1'b1));
    exp_begin(1); void'(exp_sym(1, 8'hA5, 8, 1'b1));
    send_pair(0, 8'h5A, 1, 8'hA5);
    settle();
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front(); o = obs_buf[obs_rd]; obs_rd++;
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL rstmid strobe: got d=%h w=%0d done=%b g=%0d want d=%h w=%0d done=%b g=%0d", o.d, o.w, o.done, o.g, e.d, e.w, e.done, e.g); end
    end
    checks++;
    if (exp_q.size() != 0 || obs_rd != obs_wr) begin fails++; $display("[TB] FAIL rstmid count: got %0d extra strobes want 0, %0d missing", obs_wr - obs_rd, exp_q.size()); exp_q.delete(); obs_rd = obs_wr; end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.req_width = '0;
    $display("[TB] starting huff_enc_arbiter bench");
    test_reset();
    test_round_robin();
    test_single_pad();
    test_requester3();
    test_width_err();
    test_max_sym();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/huff_enc_arbiter.md
# huff_enc_arbiter

Round-robin scheduler that shares one Huffman bit-packer (8-bit code / 4-bit width symbol input, no backpressure) among N symbol streams from the CNN weight-compression path. It grants one requester for a whole packet, forwards that requester's symbols one per cycle, and optionally prefixes a channel-ID header. It zero-pads the packet tail to a byte boundary, so packed output bytes never mix two packets.

## Interface
- N, 4, number of requesters (2..8)
- W, 8, symbol data width; codes MSB-aligned, unused LSBs zero
- C, 4, symbol width-field width
- MAX_SYM, 255, maximum symbols per packet before forced termination
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N  per-requester symbol valid
- req_last  in  N  symbol is last of packet
- req_data  in  N*W  packed codes, requester i at [i*W +: W]
- req_width  in  N*C  packed code lengths, requester i at [i*C +: C]
- req_ready  out  N  symbol accepted when valid&ready
- enc_d  out  W  symbol to packer
- enc_w  out  C  symbol length to packer
- enc_en  out  1  symbol strobe to packer
- grant_id  out  clog2(N)  currently/last granted requester
- pkt_done  out  1  one-cycle pulse when packet fully issued, padding included
- err  out  1  sticky: illegal width or MAX_SYM overrun; cleared only by rst

## Operation
- FSM states: IDLE, HDR, STREAM, PAD.
- IDLE: no req_ready. If any req_valid, pick the first set bit after rr_ptr, cyclic. Latch grant_id and set rr_ptr := grant. Go to HDR if the header is compiled in, else STREAM. bit_cnt := 0, sym_cnt := 0.
- HDR: emit enc_d = grant_id MSB-aligned, enc_w = clog2(N), enc_en=1. bit_cnt += clog2(N). Next: STREAM.
- STREAM: req_ready[grant_id]=1, others 0. On handshake:
  - width 1..W: forward data/width with enc_en=1. bit_cnt = (bit_cnt+width) mod 8. sym_cnt++.
  - width 0: accept and drop, no enc_en.
  - width > W: forward with enc_w = W and set err.
  - On req_last, or when sym_cnt reaches MAX_SYM (set err in that case): go to PAD if the updated bit_cnt ≠ 0, else IDLE with pkt_done.
- PAD: emit enc_d=0, enc_w = 8 − bit_cnt, enc_en=1, pkt_done=1. Next: IDLE.
- A MAX_SYM-forced end does not drain the requester. Its remaining symbols start a new packet on a later grant.
- Reset values: req_ready=0, enc_d=0, enc_w=0, enc_en=0, grant_id=0, pkt_done=0, err=0. rr_ptr=N−1, so requester 0 wins first. FSM returns to IDLE.
- Reset mid-packet: abandon the packet immediately; no pad is emitted. The packer is reset by the same rst.
- Symbols are never split or reordered.

## Timing
- req_ready is combinational from registered state only, never from req_valid.
- enc_d/enc_w/enc_en are registered: 1-cycle latency from handshake or state entry.
- Throughput in STREAM: one symbol per clk.
- Per-packet overhead: 1 IDLE cycle + 1 HDR cycle (if enabled) + 0/1 PAD cycle.
- pkt_done asserts in the same cycle as the enc_en of the final pad or final symbol.
- A requester with valid low in STREAM stalls with the grant held; there is no timeout.
- Re-arbitration happens only in IDLE, never mid-packet.

## Configuration
- HUFF_ARB_HDR_EN defined: HDR state present; each packet starts with a clog2(N)-bit channel ID symbol.
- HUFF_ARB_HDR_EN undefined: HDR state removed; IDLE goes directly to STREAM; the packed stream carries payload only.

## Structure
- Shared package huff_pkg holds:
  - FSM state enum.
  - Default W, C, MAX_SYM.
  - BYTE_W=8 constant.
  - ID-width function clog2.
- Sub-module rr_arbiter: N-bit request vector plus pointer in, one-hot grant and index out, purely combinational. The pointer register lives in the parent.

## Test plan
- Single requester 0, symbols (0xA0,w3),(0xC0,w2) with last, header off -> enc strobes w3, w2, then pad (0x00,w3); pkt_done with pad.
- Requesters 0 and 2 both valid, each 1-symbol packet of w8 -> grant 0 then 2, no PAD states, rr_ptr=2 afterwards.
- HUFF_ARB_HDR_EN, N=4, requester 3 sends (0x80,w1) last -> enc sequence (0xC0,w2), (0x80,w1), (0x00,w5).
- Width 0 and width 12 symbols -> width 0 dropped without enc_en; width 12 forwarded as w8 and err sets and stays set.
- MAX_SYM=3, requester streams 5 symbols of w1 without last -> 3 forwarded, pad w5, err=1, pkt_done; remaining 2 sent in a new packet.
- rst asserted in STREAM mid-packet -> next cycle all outputs at reset values; afterwards requester 0 wins the first grant.
